pbit_sweep: RTL and testbench

//  Sequential p-bit update engine that drives the local-field encoder stage and consumes its result.
//  - Each step presents the current state vector plus a one-hot index to the encoder.
//  - It captures the returned signed 32-bit field and scales it by inverse temperature beta.
//  - It compares the scaled field against an LFSR random sample and writes back the selected bit.
//  - It sweeps all PBITS bits in order, for num_sweeps sweeps (Gibbs sampling).

---
 rtl/pbit_pkg.sv | 14 +
 rtl/pbit_lfsr.sv | 18 +
 rtl/pbit_sweep.sv | 116 +++++++++++
 tb/tb_pbit_sweep.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pbit_pkg.sv
// pbit_pkg: shared FSM encoding, LFSR taps and arithmetic helpers for the p-bit sweep engine
package pbit_pkg;
  typedef enum logic [1:0] {IDLE, EVAL, COMMIT, DONE} fsm_e;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  function automatic logic signed [31:0] sat_signed(input logic signed [63:0] v, input int w);
    logic signed [63:0] mx, mn;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    return (v > mx) ? mx[31:0] : (v < mn) ? mn[31:0] : v[31:0];
  endfunction
  function automatic logic [31:0] onehot(input int p);
    return 32'd1 << p;
  endfunction
endpackage

// File: rtl/pbit_lfsr.sv
// pbit_lfsr: 32-bit Galois LFSR (x^32+x^22+x^2+x+1) advancing once per adv pulse
module pbit_lfsr
  import pbit_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2345
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  output logic [31:0] rnd
);
  logic [31:0] lfsr_q, lfsr_d;
  // next value: shift right, fold taps in when the outgoing bit is set
  always_comb lfsr_d = adv ? ((lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0)) : lfsr_q;
  // LFSR register, reseeded on reset
  always_ff @(posedge clk) lfsr_q <= rst ? SEED : lfsr_d;
  assign rnd = lfsr_q;
endmodule

// File: rtl/pbit_sweep.sv
// pbit_sweep: Gibbs p-bit sweep engine; define PBIT_ANNEAL_EN to ramp beta by beta_step per sweep
module pbit_sweep
  import pbit_pkg::*;
#(
  parameter int          PBITS     = 8,
  parameter int          RAND_W    = 16,
  parameter int          BETA_FRAC = 8,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2345
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PBITS-1:0] init_state,
  input  logic [15:0]      num_sweeps,
  input  logic [15:0]      beta,
  input  logic [15:0]      beta_step,
  input  logic [31:0]      field,
  output logic [PBITS-1:0] state,
  output logic [PBITS-1:0] index,
  output logic             busy,
  output logic             done,
  output logic [15:0]      sweeps_done,
  output logic [15:0]      beta_cur
);
  localparam int PW = PBITS > 1 ? $clog2(PBITS) : 1;
  localparam logic signed [31:0] SMAX = (32'sd1 <<< (RAND_W - 1)) - 32'sd1;
  localparam logic signed [31:0] SMIN = -SMAX - 32'sd1;
  fsm_e fsm_q, fsm_d;
  logic [PBITS-1:0] state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [15:0] ns_q, ns_d, sw_q, sw_d, beta_q, beta_d;
  logic signed [31:0] field_q, field_d;
  logic [31:0] rnd, oh;
  logic signed [48:0] prod, scaled;
  logic signed [31:0] sat, rnd32;
  logic new_bit, last, adv, unused;
  pbit_lfsr #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(rst), .adv(adv), .rnd(rnd));
  // scale the captured field by beta, saturate, and draw the new bit against the random sample
  always_comb begin
    prod    = 49'(field_q) * 49'($signed({1'b0, beta_q}));
    scaled  = prod >>> BETA_FRAC;
    sat     = sat_signed(64'(scaled), RAND_W);
    rnd32   = 32'($signed(rnd[RAND_W-1:0]));
    new_bit = (sat == SMAX) ? 1'b1 : (sat == SMIN) ? 1'b0 : (sat > rnd32);
    oh      = onehot(int'(ptr_q));
  end
  // next-state logic for the sweep FSM and its datapath registers
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    ptr_d   = ptr_q;
    ns_d    = ns_q;
    sw_d    = sw_q;
    beta_d  = beta_q;
    field_d = field_q;
    adv     = 1'b0;
    last    = ptr_q == PW'(PBITS - 1);
    case (fsm_q)
      IDLE: if (start) begin
        state_d = init_state;
        beta_d  = beta;
        ns_d    = num_sweeps;
        sw_d    = '0;
        ptr_d   = '0;
        fsm_d   = (num_sweeps == 16'd0) ? DONE : EVAL;
      end
      EVAL: begin
        field_d = $signed(field);
        fsm_d   = COMMIT;
      end
      COMMIT: begin
        adv     = 1'b1;
        state_d = (state_q & ~oh[PBITS-1:0]) | (new_bit ? oh[PBITS-1:0] : '0);
        ptr_d   = last ? '0 : ptr_q + 1'b1;
        sw_d    = last ? sw_q + 16'd1 : sw_q;
        fsm_d   = (last && sw_q + 16'd1 == ns_q) ? DONE : EVAL;
`ifdef PBIT_ANNEAL_EN
        if (last && sw_q + 16'd1 != ns_q)
          beta_d = ({1'b0, beta_q} + {1'b0, beta_step} > 17'h0FFFF) ? 16'hFFFF : beta_q + beta_step;
`endif
      end
      default: fsm_d = IDLE;
    endcase
  end
  // state registers; reset aborts any run
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      ptr_q   <= '0;
      ns_q    <= '0;
      sw_q    <= '0;
      beta_q  <= '0;
      field_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ns_q    <= ns_d;
      sw_q    <= sw_d;
      beta_q  <= beta_d;
      field_q <= field_d;
    end
  end
`ifdef PBIT_ANNEAL_EN
  assign unused = ^{rnd[31:RAND_W], oh[31:PBITS]};
`else
  assign unused = ^{beta_step, rnd[31:RAND_W], oh[31:PBITS]};
`endif
  assign state       = state_q;
  assign index       = (fsm_q == EVAL || fsm_q == COMMIT) ? oh[PBITS-1:0] : '0;
  assign busy        = fsm_q != IDLE;
  assign done        = fsm_q == DONE;
  assign sweeps_done = sw_q;
  assign beta_cur    = beta_q;
endmodule

// File: tb/tb_pbit_sweep.sv
// tb_pbit_sweep: table-driven scoreboard bench for pbit_sweep (PBITS=4 main DUT, PBITS=1 statistics DUT)
module tb_pbit_sweep;
`ifdef PBIT_ANNEAL_EN
  localparam bit ANNEAL = 1'b1;
`else
  localparam bit ANNEAL = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic start;
  logic [3:0] init_state, state, index;
  logic [15:0] num_sweeps, beta, beta_step, sweeps_done, beta_cur;
  logic [31:0] field;
  logic busy, done;
  logic s1_start, s1_state, s1_index, s1_busy, s1_done;
  logic [15:0] s1_sw, s1_beta;
  pbit_sweep #(.PBITS(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .init_state(init_state), .num_sweeps(num_sweeps),
    .beta(beta), .beta_step(beta_step), .field(field), .state(state), .index(index),
    .busy(busy), .done(done), .sweeps_done(sweeps_done), .beta_cur(beta_cur));
  pbit_sweep #(.PBITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(s1_start), .init_state(1'b0), .num_sweeps(16'd1000),
    .beta(16'h0100), .beta_step(16'h0000), .field(32'd0), .state(s1_state), .index(s1_index),
    .busy(s1_busy), .done(s1_done), .sweeps_done(s1_sw), .beta_cur(s1_beta));
  typedef struct {
    logic [3:0]  st, msk;
    logic [15:0] sw, bc;
    int          lat;
  } exp_t;
  typedef struct {
    logic [31:0] f;
    logic [3:0]  init;
    logic [15:0] ns, b;
    logic [3:0]  st;
    int          lat;
  } vec_t;
  exp_t sb[$];
  vec_t tv[8];
  int cyc = 0, start_cyc = 0, checks = 0, errors = 0;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  // scoreboard consumer: every done pulse is matched against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        e = sb.pop_front();
        chk("done_state", {28'd0, state & e.msk}, {28'd0, e.st & e.msk});
        chk("sweeps_done", {16'd0, sweeps_done}, {16'd0, e.sw});
        chk("beta_cur", {16'd0, beta_cur}, {16'd0, e.bc});
        chk("latency", cyc - start_cyc, e.lat);
        chk("index_at_done", {28'd0, index}, 32'd0);
      end
    end
  end
  task automatic run(input logic [3:0] i, input logic [15:0] ns, b, bs, input logic [31:0] f,
                     input bit push, input exp_t e);
    @(negedge clk);
    init_state = i; num_sweeps = ns; beta = b; beta_step = bs; field = f;
    start = 1'b1; start_cyc = cyc;
    if (push) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=%0d required=0 pending", sb.size());
      sb.delete();
    end
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask
  task automatic chk_reset();
    chk("rst_state", {28'd0, state}, 32'd0);
    chk("rst_index", {28'd0, index}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sweeps", {16'd0, sweeps_done}, 32'd0);
    chk("rst_beta", {16'd0, beta_cur}, 32'd0);
  endtask
  initial begin
    int ones, samples, n;
    logic [15:0] prev;
    start = 1'b0; s1_start = 1'b0; init_state = '0; num_sweeps = '0;
    beta = '0; beta_step = '0; field = '0;
    tv[0] = '{32'd1000000,   4'b0000, 16'd1, 16'h0100, 4'b1111, 9};
    tv[1] = '{-32'sd1000000, 4'b1111, 16'd2, 16'h0100, 4'b0000, 17};
    tv[2] = '{32'd0,         4'b1010, 16'd0, 16'h0100, 4'b1010, 1};
    tv[3] = '{32'd32767,     4'b0000, 16'd1, 16'h0100, 4'b1111, 9};
    tv[4] = '{-32'sd32768,   4'b1111, 16'd1, 16'h0100, 4'b0000, 9};
    tv[5] = '{32'h7FFFFFFF,  4'b0101, 16'd3, 16'hFFFF, 4'b1111, 25};
    tv[6] = '{32'h80000000,  4'b1010, 16'd1, 16'hFFFF, 4'b0000, 9};
    tv[7] = '{32'd1000000,   4'b0110, 16'd0, 16'h0300, 4'b0110, 1};
    repeat (2) @(negedge clk);
    chk_reset();
    rst = 1'b0;
    run(4'b0000, 16'd2, 16'h0100, 16'h0000, 32'd1000000, 1'b0, '{4'd0, 4'd0, 16'd0, 16'd0, 0});
    repeat (3) @(negedge clk);
    chk("busy_before_abort", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      run(tv[k].init, tv[k].ns, tv[k].b, 16'h0000, tv[k].f, 1'b1,
          '{tv[k].st, 4'hF, tv[k].ns, tv[k].b, tv[k].lat});
      wait_done();
    end
    run(4'b0000, 16'd1, 16'h0100, 16'h0000, 32'd1000000, 1'b1, '{4'b1111, 4'hF, 16'd1, 16'h0100, 9});
    for (int k = 1; k <= 8; k++) begin
      chk("index_walk", {28'd0, index}, 32'd1 << ((k - 1) / 2));
      chk("busy_walk", {31'd0, busy}, 32'd1);
      if (k == 3) begin
        start = 1'b1; init_state = 4'b1010; beta = 16'h0000; num_sweeps = 16'd5;
      end
      if (k == 4) start = 1'b0;
      @(negedge clk);
    end
    wait_done();
    run(4'b0000, 16'd4, 16'h0000, 16'h0100, 32'd1000000, 1'b1,
        '{4'd0, 4'd0, 16'd4, ANNEAL ? 16'h0300 : 16'h0000, 33});
    wait_done();
    run(4'b0000, 16'd3, 16'hFF00, 16'hFFFF, 32'd1000000, 1'b1,
        '{4'b1111, 4'hF, 16'd3, ANNEAL ? 16'hFFFF : 16'hFF00, 25});
    wait_done();
    @(negedge clk);
    s1_start = 1'b1;
    @(negedge clk);
    s1_start = 1'b0;
    ones = 0; samples = 0; n = 0; prev = s1_sw;
    while (s1_done !== 1'b1 && n < 5000) begin
      if (s1_sw != prev) begin
        samples++;
        ones += int'(s1_state);
        prev = s1_sw;
      end
      @(negedge clk);
      n++;
    end
    if (s1_sw != prev) begin
      samples++;
      ones += int'(s1_state);
    end
    chk("stat_done_seen", {31'd0, s1_done}, 32'd1);
    chk("stat_sweeps", {16'd0, s1_sw}, 32'd1000);
    chk("stat_samples", samples, 1000);
    chk("stat_frac_in_range", {31'd0, ones >= 450 && ones <= 550}, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
